dna_key_watchdog: RTL and testbench
===================================

Name: dna_key_watchdog

Overview:
- Device-locked watchdog.
- Reads the 57-bit device DNA through an external DNA_PORT-style primitive.
- Receives a 64-bit key over a slow serial strobe (sclk/sdat/en), sampled in the system clock domain.
- Emits a one-cycle reset pulse whenever TIMEOUT_CYCLES elapse without key[56:0] matching the DNA.
- Sits between the configuration logic and the global reset tree.

Parameters:
- TIMEOUT_MS, default 1000: watchdog timeout in milliseconds.
- CLK_KHZ, default 50000: clk frequency in kHz.
- TIMEOUT_CYCLES, default TIMEOUT_MS*CLK_KHZ: timer terminal count; may be overridden directly.
- KEY_BITS, default 64: key shift register length; the compare uses bits [56:0].

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  key shift enable, asynchronous to clk, synchronized internally.
- sclk  in  1  key serial strobe, asynchronous; a shift occurs on its synchronized rising edge.
- sdat  in  1  key serial data, MSB first.
- dna_dout  in  1  DOUT from the DNA primitive, clocked by clk.
- dna_read  out  1  READ to the DNA primitive.
- dna_shift  out  1  SHIFT to the DNA primitive.
- dna  out  57  captured device DNA.
- dna_valid  out  1  dna holds a complete readout.
- wd_reset  out  1  one-cycle watchdog reset pulse, active high.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears:
  - dna=0, dna_valid=0, dna_read=0, dna_shift=0;
  - key register=0, key_match=0;
  - timer=0, wd_reset=0;
  - synchronizer stages=0;
  - FSM to IDLE.
- DNA FSM:
  - IDLE: one cycle after reset release, go to LOAD.
  - LOAD: dna_read=1 for exactly one cycle, then go to SHIFT with count=0.
  - SHIFT: each cycle dna <= {dna[55:0], dna_dout} and count++. dna_shift=1 on the first 56 cycles, 0 on the 57th. After 57 samples, go to DONE.
  - DONE: dna_valid=1 and stays 1 until reset; dna_read=dna_shift=0.
  - DNA readout completes 59 cycles after reset release.
- Input sync:
  - sclk passes through a 3-stage shift register (s1, s2, s3); a rising edge is detected when s2=1 and s3=0.
  - sdat and en pass through 2 stages, aligned with s2.
  - On a detected edge with synced en=1: key <= {key[62:0], sdat_sync}.
  - Inputs must hold high and low for ≥3 clk periods each; faster toggling is unsupported.
  - Shift latency: 2–3 clk cycles after the sclk edge.
- Compare: key_match <= dna_valid && (key[56:0] == dna), registered; one cycle latency. key[63:57] is ignored.
- Timer (width ceil(log2(TIMEOUT_CYCLES+1))), priority order:
  - if key_match: timer <= 0;
  - else if timer == TIMEOUT_CYCLES: timer <= 0 (wrap);
  - else timer <= timer+1.
  - The timer runs from reset release, including during the DNA read.
- Pulse: wd_reset <= (timer == TIMEOUT_CYCLES) && !key_match.
  - With no match, wd_reset is 1 for exactly one cycle every TIMEOUT_CYCLES+1 cycles.
  - The first pulse comes TIMEOUT_CYCLES+1 cycles after reset release.
  - If match and terminal count coincide, there is no pulse and the timer clears.
- A sustained match holds the timer at 0, so no pulses occur.
- A key change that breaks the match resumes counting from 0 in the cycle after key_match falls.
- Reset mid-readout aborts the readout; the FSM restarts from IDLE on release.

Test Plan:
- DNA readout: TIMEOUT_CYCLES=100; DNA model holds 57'h1A2B3C4D5E6F708. Release rst_n.
  - dna_read high for one cycle; dna_shift high for 56 cycles.
  - dna=57'h1A2B3C4D5E6F708 and dna_valid=1 at cycle 59.
- No key: TIMEOUT_CYCLES=100, key=0.
  - wd_reset pulses for one cycle at cycles 101, 202, 303 after reset release; low otherwise.
- Matching key: shift 64 bits {7'h55, DNA} MSB first with en=1, sclk period 8 clk.
  - key_match rises 1 cycle after the last shift; the timer holds 0; no wd_reset for 1000 cycles.
- en=0 during shifting: sclk toggled 64 times.
  - key unchanged (0); pulses continue every 101 cycles.
- Key broken after a match: shift one extra bit.
  - key_match falls; the next wd_reset comes 101 cycles after key_match falls.
- Reset mid-readout: assert rst_n=0 at readout cycle 30 for 2 cycles.
  - All outputs 0; the readout restarts and dna is correct 59 cycles after release.

Source files
------------

// File: rtl/dna_key_watchdog_if.sv
// Key serial strobe and DNA primitive signals, plus the watchdog status outputs.
// The master side drives the key strobe and the DNA primitive DOUT; the slave side is the watchdog.
interface dna_key_watchdog_if;
   logic        en;
   logic        sclk;
   logic        sdat;
   logic        dna_dout;
   logic        dna_read;
   logic        dna_shift;
   logic [56:0] dna;
   logic        dna_valid;
   logic        wd_reset;

   modport master (
      output en, sclk, sdat, dna_dout,
      input  dna_read, dna_shift, dna, dna_valid, wd_reset
   );

   modport slave (
      input  en, sclk, sdat, dna_dout,
      output dna_read, dna_shift, dna, dna_valid, wd_reset
   );
endinterface

// File: rtl/dna_key_watchdog.sv
// Device-locked watchdog: reads the device DNA once, compares it with a serially loaded key,
// and pulses wd_reset whenever TIMEOUT_CYCLES pass without a matching key.
module dna_key_watchdog #(
   parameter int TIMEOUT_MS     = 1000,
   parameter int CLK_KHZ        = 50000,
   parameter int TIMEOUT_CYCLES = TIMEOUT_MS * CLK_KHZ,
   parameter int KEY_BITS       = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   dna_key_watchdog_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t        state_q, state_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [56:0]   dna_q;
   logic          rd, sh, valid;

   logic          sclk_s1, sclk_s2, sclk_s3;
   logic          sdat_s1, sdat_s2;
   logic          en_s1, en_s2;
   logic          sclk_rise;

   logic [KEY_BITS-1:0] key_q;
   logic          match_q;
   logic [TW-1:0] timer_q;
   logic          terminal;
   logic          wd_q;

   // DNA readout FSM: one READ cycle, then 57 samples with SHIFT held off on the last one
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dna_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == SHIFT)
            dna_q <= {dna_q[55:0], bus.dna_dout};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd      = 1'b0;
      sh      = 1'b0;
      valid   = 1'b0;
      case (state_q)
         IDLE:  state_d = LOAD;
         LOAD: begin
            rd      = 1'b1;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            sh    = (cnt_q != 6'd56);
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd56)
               state_d = DONE;
         end
         DONE:  valid = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   // sclk gets one extra stage for edge detection; sdat/en line up with sclk_s2
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         sdat_s1 <= 1'b0;
         sdat_s2 <= 1'b0;
         en_s1   <= 1'b0;
         en_s2   <= 1'b0;
      end else begin
         sclk_s1 <= bus.sclk;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         sdat_s1 <= bus.sdat;
         sdat_s2 <= sdat_s1;
         en_s1   <= bus.en;
         en_s2   <= en_s1;
      end
   end

   assign sclk_rise = sclk_s2 & ~sclk_s3;
   assign terminal  = (timer_q == TW'(TIMEOUT_CYCLES));

   // Match clears the timer with priority over the terminal-count wrap and the pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_q   <= '0;
         match_q <= 1'b0;
         timer_q <= '0;
         wd_q    <= 1'b0;
      end else begin
         if (sclk_rise && en_s2)
            key_q <= (key_q << 1) | KEY_BITS'(sdat_s2);
         match_q <= valid && (key_q[56:0] == dna_q);
         wd_q    <= terminal && !match_q;
         if (match_q)
            timer_q <= '0;
         else if (terminal)
            timer_q <= '0;
         else
            timer_q <= timer_q + TW'(1);
      end
   end

   assign bus.dna_read  = rd;
   assign bus.dna_shift = sh;
   assign bus.dna       = dna_q;
   assign bus.dna_valid = valid;
   assign bus.wd_reset  = wd_q;
endmodule

// File: tb/tb_dna_key_watchdog.sv
// Scoreboard bench for dna_key_watchdog: a cycle-level reference model predicts pulse and
// readout events into queues, and an independent negedge monitor pops and compares them.
module tb_dna_key_watchdog;
   localparam int          T       = 100;
   localparam logic [56:0] DNA_VAL = 57'h1A2B3C4D5E6F708;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dna_key_watchdog_if bus();

   dna_key_watchdog #(.TIMEOUT_CYCLES(T)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // DNA_PORT-style primitive: READ loads, SHIFT moves the next bit onto DOUT
   logic [56:0] prim = '0;
   always @(posedge clk) begin
      if (bus.dna_read)       prim <= DNA_VAL;
      else if (bus.dna_shift) prim <= {prim[55:0], 1'b0};
   end
   assign bus.dna_dout = prim[56];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference model: edges since release, key contents, match flag, elapsed count
   typedef struct { int due; logic b; logic e; } shift_t;
   int          rel = 0;
   logic [63:0] m_key;
   logic        m_match;
   int          m_timer;
   shift_t      pend[$];
   int          exp_pulse[$];
   int          exp_dna[$];

   task automatic model_step();
      logic pulse, nmatch;
      shift_t s;
      if (!rst_n) begin
         rel = 0; m_key = '0; m_match = 1'b0; m_timer = 0;
         pend.delete();
      end else begin
         rel++;
         pulse   = (m_timer == T) && !m_match;
         nmatch  = (rel - 1 >= 59) && (m_key[56:0] == DNA_VAL);
         m_timer = m_match ? 0 : ((m_timer == T) ? 0 : m_timer + 1);
         m_match = nmatch;
         if (pend.size() > 0 && pend[0].due == rel) begin
            s = pend.pop_front();
            if (s.e) m_key = {m_key[62:0], s.b};
         end
         if (pulse)     exp_pulse.push_back(rel);
         if (rel == 59) exp_dna.push_back(rel);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Inputs change just after an edge, so the synced rising edge shifts the key 3 edges later
   task automatic drive_bit(input logic b, input logic e, input int hi, input int lo);
      shift_t s;
      bus.sclk = 1'b1; bus.sdat = b; bus.en = e;
      s.due = rel + 3; s.b = b; s.e = e;
      pend.push_back(s);
      repeat (hi) tick();
      bus.sclk = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic reset_check(input string tag);
      @(negedge clk);
      check({tag, "_dna_read"},  64'(bus.dna_read),  64'd0);
      check({tag, "_dna_shift"}, 64'(bus.dna_shift), 64'd0);
      check({tag, "_dna"},       64'(bus.dna),       64'd0);
      check({tag, "_dna_valid"}, 64'(bus.dna_valid), 64'd0);
      check({tag, "_wd_reset"},  64'(bus.wd_reset),  64'd0);
   endtask

   // Monitor: compares DUT events against the model's queued expectations
   initial begin
      int   rd_cnt, sh_cnt, c;
      logic prev_v;
      rd_cnt = 0; sh_cnt = 0; prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rel == 0) begin
            rd_cnt = 0; sh_cnt = 0; prev_v = 1'b0;
         end else begin
            if (bus.dna_read)  rd_cnt++;
            if (bus.dna_shift) sh_cnt++;
            if (bus.wd_reset === 1'b1) begin
               if (exp_pulse.size() == 0) check("pulse_unexpected", 64'd1, 64'd0);
               else begin
                  c = exp_pulse.pop_front();
                  check("pulse_cycle", 64'(rel), 64'(c));
               end
            end
            if (bus.dna_valid === 1'b1 && !prev_v) begin
               if (exp_dna.size() == 0) check("dna_valid_unexpected", 64'(rel), 64'd0);
               else begin
                  c = exp_dna.pop_front();
                  check("dna_valid_cycle", 64'(rel), 64'(c));
                  check("dna_value", 64'(bus.dna), 64'(DNA_VAL));
                  check("dna_read_cycles", 64'(rd_cnt), 64'd1);
                  check("dna_shift_cycles", 64'(sh_cnt), 64'd56);
               end
            end
            prev_v = (bus.dna_valid === 1'b1);
         end
      end
   end

   initial begin
      logic [63:0] k;
      bus.sclk = 1'b0; bus.sdat = 1'b0; bus.en = 1'b0;
      rst_n = 1'b0;
      tick(); tick();
      reset_check("rst0");
      rst_n = 1'b1;

      // No key: readout plus pulses at 101, 202, 303
      repeat (320) tick();

      // en held low: key stays zero, pulses keep coming
      for (int i = 0; i < 64; i++)
         drive_bit(1'($urandom_range(0, 1)), 1'b0, $urandom_range(3, 5), $urandom_range(3, 5));
      repeat (50) tick();

      // Matching key with random upper bits, then a long quiet window
      k = {7'($urandom), DNA_VAL};
      for (int i = 63; i >= 0; i--)
         drive_bit(k[i], 1'b1, 4, 4);
      repeat (1000) tick();

      // One extra bit breaks the match
      drive_bit(1'($urandom_range(0, 1)), 1'b1, 4, 4);
      repeat (250) tick();

      // Full reset, then a reset in the middle of the readout
      rst_n = 1'b0;
      tick();
      reset_check("rst1");
      rst_n = 1'b1;
      repeat (30) tick();
      rst_n = 1'b0;
      tick();
      reset_check("rst_mid");
      tick();
      rst_n = 1'b1;
      repeat (200) tick();

      @(negedge clk);
      check("pulse_queue_left", 64'(exp_pulse.size()), 64'd0);
      check("dna_queue_left",   64'(exp_dna.size()),   64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
